// File: rtl/addr_map_unit.sv
`timescale 1ns/1ps
// addr_map_unit: a rule table of base/length/attribute entries that firmware can reprogram and lock.
// All rules are matched in parallel, the lowest index wins, and the result is registered behind valid/ready.
module addr_map_unit #(
    parameter int unsigned NumRules  = 10,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NumRules > 1) ? $clog2(NumRules) : 1,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstBase = {
        64'h0000_0000_0000_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_0200_0000,
        64'h0000_0000_0C00_0000, 64'h0000_0000_1000_0000, 64'h0000_0000_1800_0000,
        64'h0000_0000_2000_0000, 64'h0000_0000_3000_0000, 64'h0000_0000_4000_0000,
        64'h0000_0000_8000_0000},
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstLength = {
        64'h0000_0000_0000_1000, 64'h0000_0000_0001_0000, 64'h0000_0000_000C_0000,
        64'h0000_0000_0400_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000,
        64'h0000_0000_0080_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_1000,
        64'h0000_0000_4000_0000},
    parameter logic [NumRules-1:0][4:0] RstAttr = {5'b00101, 5'b00101, {7{5'b00001}}, 5'b10111},
    parameter logic [31:0] ErrCntRst = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IdxWidth-1:0]  resp_idx_o,
    output logic [3:0]           resp_attr_o,
    output logic                 resp_err_o,
    output logic [31:0]          err_cnt_o
);

    logic [NumRules-1:0][AddrWidth-1:0] base_q;
    logic [NumRules-1:0][AddrWidth-1:0] len_q;
    logic [NumRules-1:0][4:0]           attr_q;
    logic                               lock_q;

    logic [NumRules-1:0] hit;
    logic                match_found;
    logic [IdxWidth-1:0] match_idx;
    logic [3:0]          match_attr;
    logic                cfg_idx_ok;
    logic                cfg_wr_en;
    logic [AddrWidth-1:0] rd_val;
    logic                req_fire;

    // The offset test is done after checking addr >= base, so the subtraction never wraps
    // and a rule ending exactly at the top of the address space still matches correctly.
    always_comb begin
        for (int i = 0; i < NumRules; i++) begin
            hit[i] = attr_q[i][0] && (req_addr_i >= base_q[i]) &&
                     ((req_addr_i - base_q[i]) < len_q[i]);
        end
    end

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_attr  = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_found = 1'b1;
                match_idx   = IdxWidth'(i);
                match_attr  = attr_q[i][4:1];
            end
        end
    end

    assign cfg_idx_ok = 32'(cfg_idx_i) < NumRules;
    assign cfg_wr_en  = cfg_req_i && cfg_we_i && cfg_idx_ok && !lock_q;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NumRules; i++) begin
            if (cfg_idx_i == IdxWidth'(i)) begin
                case (cfg_field_i)
                    2'd0:    rd_val = base_q[i];
                    2'd1:    rd_val = len_q[i];
                    2'd2:    rd_val = {{(AddrWidth-5){1'b0}}, attr_q[i]};
                    default: rd_val = {{(AddrWidth-1){1'b0}}, lock_q};
                endcase
            end
        end
    end

    // Table updates land after this edge, so a same-cycle lookup still decodes against the old table.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= RstBase;
            len_q       <= RstLength;
            attr_q      <= RstAttr;
            lock_q      <= 1'b0;
            cfg_rdata_o <= '0;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_err_o <= cfg_req_i && (!cfg_idx_ok || (cfg_we_i && lock_q));
            if (cfg_req_i && !cfg_we_i) begin
                cfg_rdata_o <= cfg_idx_ok ? rd_val : '0;
            end
            for (int i = 0; i < NumRules; i++) begin
                if (cfg_wr_en && cfg_idx_i == IdxWidth'(i)) begin
                    case (cfg_field_i)
                        2'd0:    base_q[i] <= cfg_wdata_i;
                        2'd1:    len_q[i]  <= cfg_wdata_i;
                        2'd2:    attr_q[i] <= cfg_wdata_i[4:0];
                        default: if (cfg_wdata_i[0]) lock_q <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign req_ready_o = !resp_valid_o || resp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_o <= 1'b0;
            resp_idx_o   <= '0;
            resp_attr_o  <= '0;
            resp_err_o   <= 1'b0;
            err_cnt_o    <= ErrCntRst;
        end else if (req_fire) begin
            resp_valid_o <= 1'b1;
            resp_idx_o   <= match_idx;
            resp_attr_o  <= match_attr;
            resp_err_o   <= !match_found;
            if (!match_found && err_cnt_o != 32'hFFFF_FFFF) begin
                err_cnt_o <= err_cnt_o + 32'd1;
            end
        end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addr_map_unit.sv
`timescale 1ns/1ps
// tb_addr_map_unit: directed and randomized stimulus for addr_map_unit, compared every cycle
// against a rule-table reference model, plus literal expectations from the SoC memory map.
module tb_addr_map_unit;

    localparam int N  = 10;
    localparam int AW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    logic cfg_req, cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0] cfg_field;
    logic [AW-1:0] cfg_wdata, cfg_rdata;
    logic cfg_err;
    logic req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] resp_idx;
    logic [3:0] resp_attr;
    logic [31:0] err_cnt;

    logic req_valid2, req_ready2, resp_valid2, resp_err2, cfg_err2;
    logic [IW-1:0] resp_idx2;
    logic [3:0] resp_attr2;
    logic [31:0] err_cnt2;
    logic [AW-1:0] cfg_rdata2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_map_unit dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_idx_o(resp_idx),
        .resp_attr_o(resp_attr), .resp_err_o(resp_err), .err_cnt_o(err_cnt)
    );

    addr_map_unit #(.ErrCntRst(32'hFFFF_FFFD)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(1'b0), .cfg_we_i(1'b0), .cfg_idx_i(4'd0), .cfg_field_i(2'd0),
        .cfg_wdata_i(64'd0), .cfg_rdata_o(cfg_rdata2), .cfg_err_o(cfg_err2),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_addr_i(64'h5000_0000),
        .resp_valid_o(resp_valid2), .resp_ready_i(1'b1), .resp_idx_o(resp_idx2),
        .resp_attr_o(resp_attr2), .resp_err_o(resp_err2), .err_cnt_o(err_cnt2)
    );

    // Reference model: the rule table as plain arrays, plus what the outputs must show.
    logic [AW-1:0] m_base [N];
    logic [AW-1:0] m_len  [N];
    logic [4:0]    m_attr [N];
    logic          m_lock;
    logic          m_valid, m_rerr, m_cfg_err, m_rd_chk;
    int            m_idx;
    logic [3:0]    m_rattr;
    logic [31:0]   m_cnt;
    logic [AW-1:0] m_rdata;

    function automatic void model_reset();
        m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000; m_attr[0] = 5'b10111;
        m_base[1] = 64'h4000_0000; m_len[1] = 64'h1000;      m_attr[1] = 5'b00001;
        m_base[2] = 64'h3000_0000; m_len[2] = 64'h1_0000;    m_attr[2] = 5'b00001;
        m_base[3] = 64'h2000_0000; m_len[3] = 64'h80_0000;   m_attr[3] = 5'b00001;
        m_base[4] = 64'h1800_0000; m_len[4] = 64'h1000;      m_attr[4] = 5'b00001;
        m_base[5] = 64'h1000_0000; m_len[5] = 64'h1000;      m_attr[5] = 5'b00001;
        m_base[6] = 64'h0C00_0000; m_len[6] = 64'h400_0000;  m_attr[6] = 5'b00001;
        m_base[7] = 64'h0200_0000; m_len[7] = 64'hC_0000;    m_attr[7] = 5'b00001;
        m_base[8] = 64'h0001_0000; m_len[8] = 64'h1_0000;    m_attr[8] = 5'b00101;
        m_base[9] = 64'h0;         m_len[9] = 64'h1000;      m_attr[9] = 5'b00101;
        m_lock = 1'b0;
    endfunction

    // Range test done in 65 bits so base+length past the top of memory cannot wrap.
    function automatic void model_lookup(input logic [AW-1:0] a, output logic err,
                                         output int idx, output logic [3:0] at);
        logic [AW:0] lo, hi;
        err = 1'b1; idx = 0; at = 4'd0;
        for (int i = 0; i < N; i++) begin
            lo = {1'b0, m_base[i]};
            hi = lo + {1'b0, m_len[i]};
            if (m_attr[i][0] && {1'b0, a} >= lo && {1'b0, a} < hi) begin
                err = 1'b0; idx = i; at = m_attr[i][4:1];
                break;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic rdy, e;
        int ix;
        logic [3:0] at;
        if (rst) begin
            model_reset();
            m_valid = 1'b0; m_rerr = 1'b0; m_idx = 0; m_rattr = 4'd0;
            m_cnt = 32'd0; m_cfg_err = 1'b0; m_rd_chk = 1'b0; m_rdata = '0;
        end else begin
            rdy = !m_valid || resp_ready;
            if (req_valid && rdy) begin
                model_lookup(req_addr, e, ix, at);
                m_valid = 1'b1; m_rerr = e; m_idx = ix; m_rattr = at;
                if (e && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
            m_cfg_err = 1'b0;
            m_rd_chk  = 1'b0;
            if (cfg_req) begin
                if (int'(cfg_idx) >= N) begin
                    m_cfg_err = 1'b1;
                    if (!cfg_we) begin m_rd_chk = 1'b1; m_rdata = '0; end
                end else if (cfg_we) begin
                    if (m_lock) m_cfg_err = 1'b1;
                    else case (cfg_field)
                        2'd0: m_base[cfg_idx] = cfg_wdata;
                        2'd1: m_len[cfg_idx]  = cfg_wdata;
                        2'd2: m_attr[cfg_idx] = cfg_wdata[4:0];
                        default: if (cfg_wdata[0]) m_lock = 1'b1;
                    endcase
                end else begin
                    m_rd_chk = 1'b1;
                    case (cfg_field)
                        2'd0: m_rdata = m_base[cfg_idx];
                        2'd1: m_rdata = m_len[cfg_idx];
                        2'd2: m_rdata = AW'(m_attr[cfg_idx]);
                        default: m_rdata = AW'(m_lock);
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [AW-1:0] actual,
                               input logic [AW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sampled 1ns before each rising edge, after inputs have settled.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            checkOutput("model_resp_valid", AW'(resp_valid), AW'(m_valid));
            checkOutput("model_req_ready", AW'(req_ready), AW'(!m_valid || resp_ready));
            checkOutput("model_cfg_err", AW'(cfg_err), AW'(m_cfg_err));
            checkOutput("model_err_cnt", AW'(err_cnt), AW'(m_cnt));
            if (m_valid) begin
                checkOutput("model_resp_idx", AW'(resp_idx), AW'(m_idx));
                checkOutput("model_resp_attr", AW'(resp_attr), AW'(m_rattr));
                checkOutput("model_resp_err", AW'(resp_err), AW'(m_rerr));
            end
            if (m_rd_chk) checkOutput("model_cfg_rdata", cfg_rdata, m_rdata);
        end
    end

    task automatic applyStimulus(input logic lk, input logic [AW-1:0] addr, input logic cq,
                                 input logic we, input logic [IW-1:0] idx,
                                 input logic [1:0] fld, input logic [AW-1:0] wd);
        req_valid = lk; req_addr = addr;
        cfg_req = cq; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; cfg_req = 1'b0;
    endtask

    task automatic lookupCheck(input logic [AW-1:0] addr, input int eidx,
                               input logic [3:0] eattr, input logic eerr);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, 2'd0, '0);
        #4;
        checkOutput("lit_valid", AW'(resp_valid), 64'd1);
        checkOutput("lit_idx", AW'(resp_idx), AW'(eidx));
        checkOutput("lit_attr", AW'(resp_attr), AW'(eattr));
        checkOutput("lit_err", AW'(resp_err), AW'(eerr));
        @(negedge clk);
    endtask

    task automatic cfgWrite(input logic [IW-1:0] idx, input logic [1:0] fld, input logic [AW-1:0] wd);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, idx, fld, wd);
    endtask

    task automatic cfgReadCheck(input logic [IW-1:0] idx, input logic [1:0] fld,
                                input logic [AW-1:0] exp);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, idx, fld, '0);
        #4;
        checkOutput("lit_rdata", cfg_rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] bb [4];
        logic [AW-1:0] a;
        logic [31:0] exp_sat;
        int r;
        bb[0] = 64'h8000_1000; bb[1] = 64'h1000_0004; bb[2] = 64'h5000_0000; bb[3] = 64'h1_0040;
        rst = 1'b1; resp_ready = 1'b1; req_valid = 1'b0; req_addr = '0; req_valid2 = 1'b0;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = 2'd0; cfg_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        checkOutput("rst_resp_valid", AW'(resp_valid), 64'd0);
        checkOutput("rst_resp_idx", AW'(resp_idx), 64'd0);
        checkOutput("rst_resp_attr", AW'(resp_attr), 64'd0);
        checkOutput("rst_resp_err", AW'(resp_err), 64'd0);
        checkOutput("rst_cfg_rdata", cfg_rdata, 64'd0);
        checkOutput("rst_cfg_err", AW'(cfg_err), 64'd0);
        checkOutput("rst_err_cnt", AW'(err_cnt), 64'd0);
        @(negedge clk);
        cfgReadCheck(0, 2'd0, 64'h8000_0000);
        cfgReadCheck(0, 2'd1, 64'h4000_0000);
        cfgReadCheck(0, 2'd2, 64'h17);
        cfgReadCheck(9, 2'd2, 64'h5);

        lookupCheck(64'h8000_1000, 0, 4'b1011, 1'b0);
        lookupCheck(64'h1000_0004, 5, 4'b0000, 1'b0);
        lookupCheck(64'h5000_0000, 0, 4'b0000, 1'b1);
        #4 checkOutput("lit_err_cnt_one", AW'(err_cnt), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = bb[i % 4];
            @(negedge clk);
        end
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4 checkOutput("stall_req_ready", AW'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = bb[(i + 1) % 4];
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);

        cfgWrite(9, 2'd0, 64'h8000_0000);
        cfgWrite(9, 2'd1, 64'h1000);
        lookupCheck(64'h8000_0800, 0, 4'b1011, 1'b0);
        cfgWrite(0, 2'd2, 64'b10110);
        lookupCheck(64'h8000_0800, 9, 4'b0010, 1'b0);

        cfgWrite(8, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        cfgWrite(8, 2'd1, 64'h1000);
        lookupCheck(64'hFFFF_FFFF_FFFF_FFFF, 8, 4'b0010, 1'b0);
        lookupCheck(64'h0, 0, 4'b0000, 1'b1);
        lookupCheck(64'hFFFF_FFFF_FFFF_EFFF, 0, 4'b0000, 1'b1);
        lookupCheck(64'h1000_1000, 0, 4'b0000, 1'b1);
        lookupCheck(64'h1000_0FFF, 5, 4'b0000, 1'b0);
        cfgWrite(4, 2'd1, 64'h0);
        lookupCheck(64'h1800_0000, 0, 4'b0000, 1'b1);

        applyStimulus(1'b1, 64'h1000_0000, 1'b1, 1'b1, 5, 2'd0, 64'h1100_0000);
        #4;
        checkOutput("same_cycle_idx", AW'(resp_idx), 64'd5);
        checkOutput("same_cycle_err", AW'(resp_err), 64'd0);
        @(negedge clk);
        lookupCheck(64'h1000_0000, 0, 4'b0000, 1'b1);
        cfgReadCheck(5, 2'd0, 64'h1100_0000);

        cfgWrite(0, 2'd3, 64'h1);
        cfgReadCheck(0, 2'd3, 64'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 3, 2'd0, 64'h1234_0000);
        #4 checkOutput("locked_write_err", AW'(cfg_err), 64'd1);
        @(negedge clk);
        #4 checkOutput("locked_err_pulse", AW'(cfg_err), 64'd0);
        @(negedge clk);
        cfgReadCheck(3, 2'd0, 64'h2000_0000);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 12, 2'd0, '0);
        #4;
        checkOutput("bad_idx_err", AW'(cfg_err), 64'd1);
        checkOutput("bad_idx_rdata", cfg_rdata, 64'd0);
        @(negedge clk);

        resp_ready = 1'b0;
        applyStimulus(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0, 2'd0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #4 checkOutput("midstream_rst_valid", AW'(resp_valid), 64'd0);
        @(negedge clk);
        cfgReadCheck(0, 2'd3, 64'h0);
        cfgReadCheck(5, 2'd0, 64'h1000_0000);
        cfgReadCheck(4, 2'd1, 64'h1000);
        cfgReadCheck(0, 2'd2, 64'h17);

        for (int c = 0; c < 3000; c++) begin
            rst = (c % 1000 == 999);
            req_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, N - 1);
            case ($urandom_range(0, 4))
                0: a = m_base[r];
                1: a = m_base[r] + m_len[r] - 64'd1;
                2: a = m_base[r] + m_len[r];
                3: a = m_base[r] + AW'($urandom_range(0, 255));
                default: a = {$urandom, $urandom};
            endcase
            req_addr = a;
            resp_ready = ($urandom_range(0, 3) != 0);
            cfg_req = ($urandom_range(0, 9) == 0);
            cfg_we = 1'($urandom_range(0, 1));
            cfg_idx = IW'($urandom_range(0, 11));
            cfg_field = 2'($urandom_range(0, 3));
            if (cfg_field == 2'd3) cfg_wdata = AW'($urandom_range(0, 29) == 0);
            else if (cfg_field == 2'd2) cfg_wdata = AW'($urandom);
            else if ($urandom_range(0, 1) == 0) cfg_wdata = {$urandom, $urandom};
            else cfg_wdata = m_base[$urandom_range(0, N - 1)] ^ AW'($urandom_range(0, 4095));
            @(negedge clk);
        end
        rst = 1'b1; req_valid = 1'b0; cfg_req = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4 checkOutput("sat_preset", AW'(err_cnt2), 64'hFFFF_FFFD);
        @(negedge clk);
        req_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_sat = (i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            #4;
            checkOutput("sat_err_cnt", AW'(err_cnt2), AW'(exp_sat));
            checkOutput("sat_resp_err", AW'(resp_err2), 64'd1);
        end
        @(negedge clk);
        req_valid2 = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_map_unit.md
# addr_map_unit

Runtime-programmable SoC address decoder that generalises the fixed peripheral map into a parametrised rule table. Each rule has a base address, a length, and attributes: valid, cached, executable, idempotent and shared. A registered lookup pipeline with a valid/ready handshake returns the matching slave index and attributes, or a decode error. The block sits between the core/crossbar request path and the AXI crossbar. Firmware can reprogram the table at boot and then lock it.

## Interface
- NumRules, default 10: number of rules (≥1).
- AddrWidth, default 64: address and data width.
- IdxWidth, default $clog2(NumRules): rule index width.
- RstBase, default the standard SoC bases (Debug 0x0, ROM 0x1_0000, CLINT 0x200_0000, PLIC 0xC00_0000, UART 0x1000_0000, Timer 0x1800_0000, SPI 0x2000_0000, Ethernet 0x3000_0000, GPIO 0x4000_0000, DRAM 0x8000_0000): per-rule reset base.
- RstLength, default the matching SoC lengths (DRAM 0x4000_0000): per-rule reset length.
- RstAttr, default valid=1 for all rules; DRAM cached+exec+shared; ROM and Debug exec: per-rule reset attributes, 5 bits each.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  config access strobe; always accepted in one cycle.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  IdxWidth  rule index.
- cfg_field_i  in  2  0 = base, 1 = length, 2 = attr, 3 = lock.
- cfg_wdata_i  in  AddrWidth  write data.
- cfg_rdata_o  out  AddrWidth  read data, registered.
- cfg_err_o  out  1  registered, 1-cycle pulse.
- req_valid_i / req_ready_o  in/out  1  lookup handshake.
- req_addr_i  in  AddrWidth  address to decode.
- resp_valid_o / resp_ready_i  out/in  1  result handshake.
- resp_idx_o  out  IdxWidth  matching rule index.
- resp_attr_o  out  4  {shared, idempotent, exec, cached}.
- resp_err_o  out  1  no rule matched.
- err_cnt_o  out  32  saturating decode-error counter.

## Operation
- Match for rule i requires all of: valid=1, addr ≥ base, and (addr − base) < length. Compute the difference at AddrWidth; it must not overflow at the top of the address space. length=0 never matches.
- If several rules match, the lowest index wins.
- If no rule matches: resp_err_o=1, resp_idx_o=0, resp_attr_o=0.
- Config write:
  - updates the field of rule cfg_idx_i, taking effect from the next cycle;
  - for field 2, only wdata[4:0] are used (bit0 valid, bit1 cached, bit2 exec, bit3 idempotent, bit4 shared);
  - for field 3, writing wdata[0]=1 sets the global lock; only rst_i clears it.
- Config read returns the field value, zero-extended, on the next cycle. Field 3 reads back the lock bit.
- cfg_err_o pulses in the following cycle for any of these:
  - a write while locked (the write is ignored);
  - cfg_idx_i ≥ NumRules (the write is ignored, or the read returns 0).
- A lookup and a config write in the same cycle: the lookup uses the pre-write table.
- err_cnt_o increments by 1 on each accepted lookup that produces resp_err_o=1, and saturates at 0xFFFF_FFFF.

## Timing
- Reset values:
  - table loads RstBase/RstLength/RstAttr; lock=0;
  - resp_valid_o=0, resp_idx_o=0, resp_attr_o=0, resp_err_o=0;
  - cfg_rdata_o=0, cfg_err_o=0, err_cnt_o=0.
- Lookup latency is 1 cycle. A request accepted at edge N (req_valid_i & req_ready_o) produces a response, held in the output register, that is valid after edge N.
- req_ready_o = !resp_valid_o || resp_ready_i, which gives full throughput (one lookup per cycle) under continuous resp_ready_i.
- While resp_valid_o=1 and resp_ready_i=0, all resp_* outputs stay stable.
- Config read data appears the cycle after cfg_req_i.
- rst_i asserted mid-stream:
  - drops resp_valid_o at the next edge;
  - discards the in-flight response;
  - restores the table and clears the lock.

## Test plan
- Reset defaults, then lookups:
  - 0x8000_1000 -> idx 0 (DRAM), attr 0b1011, err 0;
  - 0x1000_0004 -> idx 5 (UART), attr 0;
  - 0x5000_0000 -> err 1, err_cnt_o=1.
- Back-to-back lookups with resp_ready_i=1 -> one response per cycle, 1-cycle latency. Hold resp_ready_i=0 for 3 cycles -> req_ready_o=0 and outputs stable; release -> stream resumes with no loss or duplication.
- Overlap and priority:
  - program rule 9 base 0x8000_0000 length 0x1000 -> lookup of 0x8000_0800 returns idx 0 (lowest index wins);
  - clear rule 0 valid -> the same lookup returns idx 9.
- Boundaries:
  - rule base 0xFFFF_FFFF_FFFF_F000, length 0x1000 -> 0xFFFF_FFFF_FFFF_FFFF matches, with no overflow false match;
  - address base+length -> no match;
  - length 0 -> never matches.
- Lock:
  - write lock=1, then write base of rule 3 -> cfg_err_o pulses and readback is unchanged;
  - cfg_idx_i=12 -> cfg_err_o pulses;
  - rst_i -> lock=0 and the table is restored.
- Same-cycle config write and lookup:
  - write rule 5 base 0x1100_0000 while looking up 0x1000_0000 -> old match (idx 5);
  - next-cycle lookup of 0x1000_0000 -> err.
  - Also force 2^32 decode errors through the counter -> err_cnt_o holds at 0xFFFF_FFFF.
